// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, packet FSM states and block defaults.
package noc_pkg;

  localparam int FLIT_W_DEF = 34;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    PKT_IDLE   = 1'b0,
    PKT_ACTIVE = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/ifc_noc_input_buffer.sv
// Bundles the input buffer's link-side and router-side signals for benches and wrappers.
interface ifc_noc_input_buffer #(
  parameter int FLIT_W = noc_pkg::FLIT_W_DEF,
  parameter int DEPTH  = noc_pkg::DEPTH_DEF
) (
  input logic clk
);
  logic                       rst;
  logic [FLIT_W-1:0]          flit_in;
  logic                       flit_valid_in;
  logic [FLIT_W-1:0]          flit_out;
  logic                       flit_valid_out;
  logic                       flit_ready_in;
  logic                       credit_out;
  logic [$clog2(DEPTH):0]     count;
  logic                       pkt_active;
  logic                       overflow_err;

  modport dut (
    input  clk, rst, flit_in, flit_valid_in, flit_ready_in,
    output flit_out, flit_valid_out, credit_out, count, pkt_active, overflow_err
  );

  modport bench (
    input  clk, flit_out, flit_valid_out, credit_out, count, pkt_active, overflow_err,
    output rst, flit_in, flit_valid_in, flit_ready_in
  );
endinterface

// File: rtl/flit_fifo.sv
// Circular flit store with wrapping pointers; the caller decides which pushes/pops are legal.
module flit_fifo #(
  parameter int FLIT_W = noc_pkg::FLIT_W_DEF,
  parameter int DEPTH  = noc_pkg::DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [FLIT_W-1:0]      din,
  output logic [FLIT_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately not reset; contents behind an empty pointer pair are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/noc_input_buffer.sv
// Router input buffer: credit-returning FIFO with wormhole packet tracking and sticky overflow flag.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      flit_in,
  input  logic                   flit_valid_in,
  output logic [FLIT_W-1:0]      flit_out,
  output logic                   flit_valid_out,
  input  logic                   flit_ready_in,
  output logic                   credit_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   pkt_active,
  output logic                   overflow_err
);
  logic       full, empty;
  logic       pop, push;
  flit_type_t head_type;

  pkt_state_t state_q;
  logic       pkt_active_q;
  logic       credit_q;
  logic       ovf_q;

  // A full buffer still takes a flit when the head leaves in the same cycle.
  assign pop       = !empty && flit_ready_in;
  assign push      = flit_valid_in && (!full || pop);
  assign head_type = flit_type_t'(flit_out[FLIT_W-1 -: 2]);

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (flit_in),
    .dout  (flit_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= pop;
      if (flit_valid_in && !push) ovf_q <= 1'b1;
    end
  end

  // Framing errors only leave the state alone; flits are never held back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PKT_IDLE;
      pkt_active_q <= 1'b0;
    end else if (pop) begin
      case (state_q)
        PKT_IDLE: if (head_type == HEAD) begin
          state_q      <= PKT_ACTIVE;
          pkt_active_q <= 1'b1;
        end
        PKT_ACTIVE: if (head_type == TAIL) begin
          state_q      <= PKT_IDLE;
          pkt_active_q <= 1'b0;
        end
        default: begin
          state_q      <= PKT_IDLE;
          pkt_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign flit_valid_out = !empty;
  assign credit_out     = credit_q;
  assign pkt_active     = pkt_active_q;
  assign overflow_err   = ovf_q;

endmodule

// File: doc/noc_input_buffer.md
NOC_INPUT_BUFFER -- requirements
Module: noc_input_buffer

Interface
REQ-001 Parameter FLIT_W, default 34, meaning: full flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type and the rest is payload.
REQ-002 Parameter DEPTH, default 4, meaning: buffer slots; power of 2, at least 2; equals the credits granted to the upstream credit counter.
REQ-003 Port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port flit_in  input  FLIT_W  flit from the upstream link.
REQ-006 Port flit_valid_in  input  1  flit_in is valid this cycle (push request).
REQ-007 Port flit_out  output  FLIT_W  head-of-buffer flit to the downstream router stage.
REQ-008 Port flit_valid_out  output  1  flit_out is valid.
REQ-009 Port flit_ready_in  input  1  downstream accepts flit_out this cycle.
REQ-010 Port credit_out  output  1  one-cycle pulse per freed slot, returned to the upstream credit counter.
REQ-011 Port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 Port pkt_active  output  1  a wormhole packet is mid-transfer at the output.
REQ-013 Port overflow_err  output  1  sticky flag: a push arrived while the buffer was full.

Function
REQ-014 Push: the buffer SHALL accept a push when flit_valid_in=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-015 Pop: a pop SHALL occur when flit_valid_out=1 and flit_ready_in=1.
REQ-016 flit_valid_out SHALL equal (count!=0); there is no fall-through, so a flit pushed in cycle N appears at flit_out in cycle N+1 at the earliest.
REQ-017 flit_out SHALL be the oldest stored flit, in FIFO order with no reordering.
REQ-018 count SHALL update the cycle after each event: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-020 credit_out SHALL be 1 in cycle N+1 for each pop in cycle N; a pop every cycle gives back-to-back pulses.
REQ-021 Push while full without a simultaneous pop: the flit SHALL be dropped, pointers and count SHALL not change, and overflow_err SHALL be set until reset.
REQ-022 Push with flit_valid_in=1 while empty SHALL not pop in the same cycle.
REQ-023 Flit type encoding: HEAD=2'b00, BODY=2'b01, TAIL=2'b10, HEADTAIL=2'b11.
REQ-024 The packet FSM SHALL have two states, IDLE and ACTIVE, and SHALL advance only on pops.
REQ-025 FSM transitions:
- IDLE to ACTIVE on popping HEAD.
- ACTIVE to IDLE on popping TAIL.
- HEADTAIL in IDLE stays IDLE.
REQ-026 pkt_active SHALL be 1 exactly when the FSM state is ACTIVE.
REQ-027 Framing errors SHALL not block the flow; the flit still passes through. The FSM response is:
- BODY or TAIL popped in IDLE: stay IDLE.
- HEAD or HEADTAIL popped in ACTIVE: stay ACTIVE.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL clear pointers, count, credit_out, overflow_err and pkt_active to 0, set the FSM to IDLE, and ignore push and pop.
REQ-029 Reset mid-packet or mid-transfer SHALL discard all stored flits and generate no credits for them; the upstream counter is reset together with this block.
REQ-030 Storage contents are not reset; flit_out is don't-care while flit_valid_out=0.

Structure
REQ-031 Shared package noc_pkg SHALL hold the following, which this block imports:
- flit_type_t enum (HEAD, BODY, TAIL, HEADTAIL).
- FLIT_W and DEPTH defaults.
REQ-032 Storage and pointers SHALL be a sub-module flit_fifo, with parameters FLIT_W and DEPTH and ports push, pop, din, dout, count, full, empty.
REQ-033 The credit pulse, packet FSM and overflow flag SHALL reside in noc_input_buffer.
REQ-034 The interface file ifc_noc_input_buffer(clk) SHALL provide dut and bench modports for the top-level bench.

Verification (DEPTH=4)
REQ-035 Reset then push 4 flits with ready=0 -> count=4, credit_out=0, no overflow_err; a 5th push -> flit dropped, overflow_err=1, count=4.
REQ-036 Push payloads 0x11..0x14, then ready=1 -> flit_out reads 0x11, 0x12, 0x13, 0x14 on consecutive cycles; 4 credit pulses, each one cycle after its pop; count=0.
REQ-037 Full buffer with push and pop in the same cycle -> flit accepted, count stays 4, one credit pulse, FIFO order kept across pointer wrap.
REQ-038 Pop HEAD, BODY, BODY, TAIL -> pkt_active=1 from the cycle after the HEAD pop until the cycle after the TAIL pop; HEADTAIL alone -> pkt_active stays 0.
REQ-039 Assert rst with 3 flits stored and pkt_active=1 -> next cycle count=0, flit_valid_out=0, pkt_active=0, overflow_err=0, no credit pulse.
